sys_reset_seq: RTL and testbench
================================

Name: sys_reset_seq

Overview:
- Reset and clock-enable sequencer clocked by the main system clock produced by the clock generation block.
- Turns the board reset pin into a clean, sequenced core reset and a delayed peripheral reset, then starts a periodic peripheral clock-enable tick.
- The tick replaces the need for divided clocks downstream.
- Supports software-requested resets, with an optional watchdog.

Parameters:
- SYNC_STAGES, 2, number of flops in the reset-deassertion synchronizer (>=2).
- SETTLE_CYCLES, 16, cycles held in SETTLE before core reset release (>=1).
- PERIPH_DIV, 22, period of periph_tick in clk cycles (>=1).
- WDT_CYCLES, 1024, watchdog timeout in clk cycles (used only with RST_SEQ_WDT_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset (board pin).
- sw_rst_req  input  1  software reset request, sampled only in RUN.
- sw_rst_cycles  input  8  software reset hold length in cycles, sampled with the request; 0 is treated as 1.
- wdt_kick  input  1  watchdog service strobe; ignored when the feature is compiled out.
- rst_core_n  output  1  core reset, active-low.
- rst_periph_n  output  1  peripheral reset, active-low.
- periph_tick  output  1  single-cycle peripheral clock enable.
- state  output  2  current FSM state.
- reset_cause  output  2  cause of the last reset: 01 pin, 10 software, 11 watchdog.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All flops are asynchronously cleared by rst_n low. Deassertion passes through the SYNC_STAGES synchronizer before the FSM sees it.
- Reset values: rst_core_n=0, rst_periph_n=0, periph_tick=0, state=00, reset_cause=01, all counters 0.
- States: HOLD=00, SETTLE=01, RUN=10, SW_RESET=11.
- HOLD -> SETTLE: taken on the edge after the synchronizer output reads 1. With SYNC_STAGES=2, counting edge 1 as the first edge after rst_n rises, SETTLE is entered at edge 3 with settle count 0.
- SETTLE -> RUN: the count increments each edge. On the edge where count==SETTLE_CYCLES-1, the FSM enters RUN and rst_core_n goes to 1. With defaults this is edge 19.
- RUN, divider:
  - div_cnt is 0 on RUN entry and increments, wrapping from PERIPH_DIV-1 to 0.
  - periph_tick is registered. It is 1 exactly in the cycle where div_cnt==PERIPH_DIV-1; with defaults, set at edge 40 and cleared at edge 41.
  - PERIPH_DIV=1 gives periph_tick=1 every RUN cycle, starting with the RUN-entry edge.
- rst_periph_n goes to 1 on the edge after the first periph_tick (edge 41 with defaults). It stays 1 while in RUN.
- RUN -> SW_RESET: sw_rst_req=1 at edge E.
  - At E: rst_core_n=0, rst_periph_n=0, periph_tick=0, div_cnt=0, reset_cause=10.
  - The hold counter loads N=max(sw_rst_cycles,1).
  - At edge E+N the FSM goes to SETTLE, then runs the normal settle sequence; the synchronizer is not re-run.
- sw_rst_req is ignored outside RUN. A request held high re-triggers only after RUN is re-entered.
- rst_n low at any time, including mid-SETTLE or mid-SW_RESET, immediately forces the reset values. reset_cause returns to 01.
- reset_cause persists until the next reset event.

Optional Feature:
- Macro: RST_SEQ_WDT_EN.
- Defined:
  - The watchdog counter runs only in RUN and clears on wdt_kick=1 or when leaving RUN.
  - If the counter reaches WDT_CYCLES-1 with no kick, the next edge enters SW_RESET with N=1 and reset_cause=11.
  - If sw_rst_req and a watchdog expiry occur on the same edge, the software request wins: N from sw_rst_cycles, cause 10.
- Not defined: no watchdog logic is built, wdt_kick is ignored, and reset_cause never reads 11.

Test Plan:
- Power-on, defaults: rst_n low 5 cycles then high -> state 01 at edge 3, rst_core_n=1 and state 10 at edge 19, periph_tick high only in the cycle after edge 40, rst_periph_n=1 at edge 41, next tick after edge 62.
- Software reset: in RUN, sw_rst_req=1 with sw_rst_cycles=5 at edge E -> both resets 0 and cause=10 at E, state 01 at E+5, rst_core_n=1 at E+21.
- Zero length: sw_rst_cycles=0 -> SW_RESET lasts exactly 1 cycle; requests during SETTLE produce no state change.
- Async abort: rst_n low mid-SETTLE and mid-SW_RESET -> outputs reach reset values without a clock edge; cause=01.
- PERIPH_DIV=1 build: periph_tick=1 every cycle from RUN entry; rst_periph_n=1 one edge after RUN entry.
- RST_SEQ_WDT_EN build with WDT_CYCLES=8:
  - no kicks -> SW_RESET 8 edges after RUN entry, cause=11;
  - kick every 4 cycles -> never expires;
  - expiry with simultaneous sw_rst_req -> cause=10.

Source files
------------

// File: rtl/sys_reset_seq.sv
// ---------------------------------------------------------------------------
// sys_reset_seq
//
// Purpose:
//   Reset and clock-enable sequencer for the main system clock domain. It
//   turns the asynchronous board reset pin into a sequenced core reset and a
//   later peripheral reset. Once running, it produces a periodic single-cycle
//   peripheral clock enable, so downstream logic needs no divided clocks.
//   Software can request a timed reset while running.
//
// Optional feature:
//   Define RST_SEQ_WDT_EN to build the watchdog. If nobody strobes wdt_kick
//   for WDT_CYCLES cycles while running, the watchdog forces a one-cycle
//   software-style reset. Without the macro there is no watchdog logic,
//   wdt_kick is ignored and reset_cause never reads 11.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   board reset pin, asynchronous, active-low
//   sw_rst_req     in   software reset request, honoured only in RUN
//   sw_rst_cycles  in   [7:0] software reset hold length, 0 behaves as 1
//   wdt_kick       in   watchdog service strobe
//   rst_core_n     out  core reset, active-low
//   rst_periph_n   out  peripheral reset, active-low
//   periph_tick    out  single-cycle peripheral clock enable
//   state          out  [1:0] HOLD=00, SETTLE=01, RUN=10, SW_RESET=11
//   reset_cause    out  [1:0] 01 pin, 10 software, 11 watchdog
// ---------------------------------------------------------------------------
module sys_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int PERIPH_DIV    = 22,
  parameter int WDT_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic [7:0] sw_rst_cycles,
  input  logic       wdt_kick,
  output logic       rst_core_n,
  output logic       rst_periph_n,
  output logic       periph_tick,
  output logic [1:0] state,
  output logic [1:0] reset_cause
);

  typedef enum logic [1:0] {
    HOLD     = 2'b00,
    SETTLE   = 2'b01,
    RUN      = 2'b10,
    SW_RESET = 2'b11
  } state_t;

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DCW = (PERIPH_DIV > 1) ? $clog2(PERIPH_DIV) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_LAST    = DCW'(PERIPH_DIV - 1);

  state_t                 fsm;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_done;
  logic [SCW-1:0]         settle_cnt;
  logic [DCW-1:0]         div_cnt;
  logic [DCW-1:0]         div_next;
  logic [7:0]             hold_cnt;
  logic [7:0]             hold_len;
  logic                   wdt_expire;

  assign state     = fsm;
  assign sync_done = sync[SYNC_STAGES-1];
  assign div_next  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign hold_len  = (sw_rst_cycles == 8'd0) ? 8'd1 : sw_rst_cycles;

  // Reset-deassertion synchronizer: clears immediately with the pin and
  // shifts ones in afterwards. A software reset leaves it untouched, so
  // those resets go straight to SETTLE without a second synchronizer delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam int WCW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WCW-1:0] WDT_LAST = WCW'(WDT_CYCLES - 1);

  logic [WCW-1:0] wdt_cnt;

  // A kick on the expiry cycle still rescues the system.
  assign wdt_expire = (fsm == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

  // Watchdog counter. It only counts unserviced RUN cycles and holds at
  // zero everywhere else, so every RUN entry starts a full timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if ((fsm != RUN) || wdt_kick || sw_rst_req || wdt_expire) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign unused_wdt = wdt_kick | (WDT_CYCLES == 0);
  assign wdt_expire = 1'b0;
`endif

  // Main sequencer. All outputs are registered here.
  // In RUN, a software request takes priority over a watchdog expiry on the
  // same edge, so its hold length and cause are the ones recorded.
  // The peripheral reset releases on the edge after the first tick, which
  // gives peripherals one full tick period of running clock first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= HOLD;
      settle_cnt   <= '0;
      div_cnt      <= '0;
      hold_cnt     <= '0;
      rst_core_n   <= 1'b0;
      rst_periph_n <= 1'b0;
      periph_tick  <= 1'b0;
      reset_cause  <= 2'b01;
    end else begin
      case (fsm)
        HOLD: begin
          if (sync_done) begin
            fsm        <= SETTLE;
            settle_cnt <= '0;
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            fsm         <= RUN;
            rst_core_n  <= 1'b1;
            div_cnt     <= '0;
            periph_tick <= (DIV_LAST == '0);
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        RUN: begin
          if (sw_rst_req || wdt_expire) begin
            fsm          <= SW_RESET;
            rst_core_n   <= 1'b0;
            rst_periph_n <= 1'b0;
            periph_tick  <= 1'b0;
            div_cnt      <= '0;
            hold_cnt     <= sw_rst_req ? hold_len : 8'd1;
            reset_cause  <= sw_rst_req ? 2'b10 : 2'b11;
          end else begin
            div_cnt     <= div_next;
            periph_tick <= (div_next == DIV_LAST);
            if (periph_tick) begin
              rst_periph_n <= 1'b1;
            end
          end
        end

        SW_RESET: begin
          if (hold_cnt <= 8'd1) begin
            fsm        <= SETTLE;
            settle_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          fsm <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_sys_reset_seq
//
// Self-checking bench for sys_reset_seq. The reference model describes the
// sequence as a timeline. It records the edges where SETTLE and RUN begin,
// and derives every output from the edge number with plain arithmetic.
// A second instance built with PERIPH_DIV=1 runs beside the main one.
// The watchdog scenarios follow the RST_SEQ_WDT_EN macro.
// ---------------------------------------------------------------------------
module tb_sys_reset_seq;

  localparam int SYNC   = 2;
  localparam int SETTLE = 16;
  localparam int PD     = 22;
  localparam int WDT    = 8;
  localparam logic [6:0] RESET_VEC = 7'b00_01_000;

`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [7:0] sw_rst_cycles = 8'd0;
  logic       wdt_kick = 1'b0;

  logic       rst_core_n, rst_periph_n, periph_tick;
  logic [1:0] state, reset_cause;
  logic       core2, periph2, tick2;
  logic [1:0] state2, cause2;
  logic [6:0] vec, vec2;

  int checks = 0;
  int passes = 0;

  // Model state: edge_n counts edges since rst_n rose.
  int         edge_n;
  int         settle_at;
  int         run_at;
  int         last_kick;
  bit         sw_active;
  logic [1:0] cause;

  assign vec  = {state, reset_cause, rst_core_n, rst_periph_n, periph_tick};
  assign vec2 = {state2, cause2, core2, periph2, tick2};

  sys_reset_seq #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .PERIPH_DIV(PD), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .sw_rst_cycles(sw_rst_cycles),
    .wdt_kick(wdt_kick), .rst_core_n(rst_core_n), .rst_periph_n(rst_periph_n),
    .periph_tick(periph_tick), .state(state), .reset_cause(reset_cause)
  );

  sys_reset_seq #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .PERIPH_DIV(1), .WDT_CYCLES(WDT)
  ) dut_div1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(1'b0), .sw_rst_cycles(8'd0),
    .wdt_kick(1'b1), .rst_core_n(core2), .rst_periph_n(periph2),
    .periph_tick(tick2), .state(state2), .reset_cause(cause2)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Expected state after edge k, read off the event timeline.
  function automatic logic [1:0] m_state(int k);
    if (k >= run_at)    return 2'b10;
    if (k >= settle_at) return 2'b01;
    if (sw_active)      return 2'b11;
    return 2'b00;
  endfunction

  // Expected {state, cause, core, periph, tick} of the main instance.
  function automatic logic [6:0] m_vec(int k);
    logic t;
    t = (k >= run_at) && (((k - run_at) % PD) == PD - 1);
    return {m_state(k), cause, k >= run_at, k >= run_at + PD, t};
  endfunction

  // Expected vector of the PERIPH_DIV=1 instance, which sees only pin resets.
  function automatic logic [6:0] m_vec2(int k);
    int r;
    logic [1:0] s;
    r = SYNC + 1 + SETTLE;
    s = (k >= r) ? 2'b10 : ((k >= SYNC + 1) ? 2'b01 : 2'b00);
    return {s, 2'b01, k >= r, k >= r + 1, k >= r};
  endfunction

  // Restart the timeline after rst_n rises.
  task automatic model_reset();
    edge_n    = 0;
    sw_active = 1'b0;
    settle_at = SYNC + 1;
    run_at    = settle_at + SETTLE;
    last_kick = -1000;
    cause     = 2'b01;
  endtask

  // A reset event at edge k that holds for n cycles.
  task automatic sw_event(input int k, input int n, input logic [1:0] c);
    sw_active = 1'b1;
    settle_at = k + n;
    run_at    = settle_at + SETTLE;
    cause     = c;
  endtask

  // Drive one cycle of inputs at the falling edge and update the model.
  // Return #1 after the next rising edge, ready for sampling.
  task automatic step(input logic req, input logic [7:0] cyc, input logic kick);
    int k;
    int base;
    @(negedge clk);
    sw_rst_req    = req;
    sw_rst_cycles = cyc;
    wdt_kick      = kick;
    k = edge_n + 1;
    if (m_state(k - 1) == 2'b10) begin
      base = (last_kick > run_at) ? last_kick : run_at;
      if (req) begin
        sw_event(k, (cyc == 8'd0) ? 1 : int'(cyc), 2'b10);
      end else if (WDT_ON && !kick && (k == base + WDT)) begin
        sw_event(k, 1, 2'b11);
      end
    end
    if (kick) last_kick = k;
    @(posedge clk);
    edge_n = k;
    #1;
  endtask

  // Step until both the DUT and the model are in RUN, with a bounded budget.
  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (state === 2'b10 && m_state(edge_n) == 2'b10) begin
        ok = 1'b1;
        break;
      end
      step(1'b0, 8'd0, 1'b1);
    end
  endtask

  // Assert the pin between clock edges, check both instances clear at once,
  // hold it for five cycles and release just after a rising edge.
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== RESET_VEC) $display("[TB] FAIL reset_async got=%b want=%b", vec, RESET_VEC);
    else passes++;
    checks++;
    if (vec2 !== RESET_VEC) $display("[TB] FAIL reset_async_div1 got=%b want=%b", vec2, RESET_VEC);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (vec !== RESET_VEC) $display("[TB] FAIL reset_hold got=%b want=%b", vec, RESET_VEC);
      else passes++;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Power-on sequence. The model covers every edge, and the milestone
  // edges are also checked against fixed values.
  task automatic test_power_on();
    logic [4:0] want;
    bit have;
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 8'd0, 1'b1);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL pwr_model edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
      checks++;
      if (vec2 !== m_vec2(edge_n)) $display("[TB] FAIL pwr_div1 edge=%0d got=%b want=%b", edge_n, vec2, m_vec2(edge_n));
      else passes++;
      have = 1'b1;
      want = 5'b00_000;
      case (edge_n)
        2:       want = 5'b00_000;
        3:       want = 5'b01_000;
        18:      want = 5'b01_000;
        19:      want = 5'b10_100;
        39:      want = 5'b10_100;
        40:      want = 5'b10_101;
        41:      want = 5'b10_110;
        61:      want = 5'b10_110;
        62:      want = 5'b10_111;
        default: have = 1'b0;
      endcase
      if (have) begin
        checks++;
        if ({state, rst_core_n, rst_periph_n, periph_tick} !== want)
          $display("[TB] FAIL pwr_milestone edge=%0d got=%b want=%b", edge_n, {state, rst_core_n, rst_periph_n, periph_tick}, want);
        else passes++;
      end
    end
  endtask

  // Software reset with a hold of 5, issued after a random delay in RUN.
  task automatic test_sw_reset();
    int w;
    int e;
    bit ok;
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL sw_wait_run got=%b want=10", state);
    else passes++;
    w = $urandom_range(0, 30);
    for (int i = 0; i < w; i++) begin
      step(1'b0, 8'($urandom), 1'b1);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL sw_pre edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
    end
    step(1'b1, 8'd5, 1'b1);
    e = edge_n;
    checks++;
    if (vec !== 7'b11_10_000) $display("[TB] FAIL sw_enter got=%b want=%b", vec, 7'b11_10_000);
    else passes++;
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 8'd0, 1'b1);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL sw_model edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
      if (i == 4 || i == 5 || i == 20 || i == 21) begin
        checks++;
        if ({state, rst_core_n} !== ((i == 4) ? 3'b110 : (i == 21) ? 3'b101 : 3'b010))
          $display("[TB] FAIL sw_milestone E+%0d got=%b want=%b", i, {state, rst_core_n},
                   (i == 4) ? 3'b110 : (i == 21) ? 3'b101 : 3'b010);
        else passes++;
      end
    end
  endtask

  // A zero-length request holds for one cycle. Requests in SETTLE do nothing.
  // A request held through SETTLE fires on the first RUN cycle.
  task automatic test_zero_len();
    int e;
    bit ok;
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL zl_wait_run got=%b want=10", state);
    else passes++;
    step(1'b1, 8'd0, 1'b1);
    e = edge_n;
    checks++;
    if (state !== 2'b11) $display("[TB] FAIL zl_enter got=%b want=11", state);
    else passes++;
    step(1'b0, 8'd0, 1'b1);
    checks++;
    if (state !== 2'b01) $display("[TB] FAIL zl_one_cycle got=%b want=01", state);
    else passes++;
    while (edge_n < e + 18) begin
      step(1'b1, 8'd3, 1'b1);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL zl_model edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
      checks++;
      if (state !== ((edge_n <= e + 16) ? 2'b01 : (edge_n == e + 17) ? 2'b10 : 2'b11))
        $display("[TB] FAIL zl_held_req E+%0d got=%b want=%b", edge_n - e, state,
                 (edge_n <= e + 16) ? 2'b01 : (edge_n == e + 17) ? 2'b10 : 2'b11);
      else passes++;
    end
  endtask

  // Random requests, lengths and kicks, all checked against the timeline.
  task automatic test_random();
    logic req;
    logic kick;
    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 19) == 0);
      kick = WDT_ON ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      step(req, 8'($urandom_range(0, 12)), kick);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL rnd_model edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
    end
  endtask

  // Pull the pin between edges during SW_RESET and during SETTLE that
  // follows a software reset. Outputs and cause must clear without a clock.
  task automatic test_async_abort();
    bit ok;
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL ab_wait_run got=%b want=10", state);
    else passes++;
    step(1'b1, 8'd20, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1);
    checks++;
    if ({state, reset_cause} !== 4'b11_10) $display("[TB] FAIL ab_in_sw got=%b want=1110", {state, reset_cause});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== RESET_VEC) $display("[TB] FAIL ab_sw_async got=%b want=%b", vec, RESET_VEC);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL ab_rerun got=%b want=10", state);
    else passes++;
    step(1'b1, 8'd2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
    checks++;
    if ({state, reset_cause} !== 4'b01_10) $display("[TB] FAIL ab_in_settle got=%b want=0110", {state, reset_cause});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vec !== RESET_VEC) $display("[TB] FAIL ab_settle_async got=%b want=%b", vec, RESET_VEC);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 8'd0, 1'b1);
      checks++;
      if (vec !== m_vec(edge_n)) $display("[TB] FAIL ab_restart edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
    end
  endtask

`ifdef RST_SEQ_WDT_EN
  // Watchdog build. Check expiry with no kicks, no expiry when kicking every
  // 4 cycles, and a software request that lands on the expiry edge.
  task automatic test_watchdog();
    bit ok;
    int tgt;
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL wd_wait_run got=%b want=10", state);
    else passes++;
    step(1'b1, 8'd1, 1'b1);
    for (int i = 0; i < 40 && edge_n < run_at; i++) step(1'b0, 8'd0, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 8'd0, 1'b0);
      checks++;
      if ({state, reset_cause} !== ((j == 8) ? 4'b11_11 : 4'b10_10))
        $display("[TB] FAIL wd_expire j=%0d got=%b want=%b", j, {state, reset_cause}, (j == 8) ? 4'b11_11 : 4'b10_10);
      else passes++;
    end
    wait_run(ok);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'd0, (i % 4) == 0);
      checks++;
      if (state !== 2'b10 || vec !== m_vec(edge_n))
        $display("[TB] FAIL wd_kicked edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
    end
    tgt = ((last_kick > run_at) ? last_kick : run_at) + WDT;
    for (int i = 0; i < 20 && edge_n < tgt - 1; i++) step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    checks++;
    if ({state, reset_cause} !== 4'b11_10) $display("[TB] FAIL wd_sw_wins got=%b want=1110", {state, reset_cause});
    else passes++;
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1);
    checks++;
    if (state !== 2'b01) $display("[TB] FAIL wd_sw_len got=%b want=01", state);
    else passes++;
  endtask
`else
  // Watchdog compiled out: a long run with no kicks stays in RUN with no
  // watchdog cause.
  task automatic test_watchdog();
    bit ok;
    wait_run(ok);
    checks++;
    if (!ok) $display("[TB] FAIL wd_wait_run got=%b want=10", state);
    else passes++;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'd0, 1'b0);
      checks++;
      if (state !== 2'b10 || reset_cause === 2'b11 || vec !== m_vec(edge_n))
        $display("[TB] FAIL wd_absent edge=%0d got=%b want=%b", edge_n, vec, m_vec(edge_n));
      else passes++;
    end
  endtask
`endif

  // Scenario sequence, then the summary line.
  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_sw_reset();
    test_zero_len();
    test_async_abort();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
